// File: rtl/iter_alu.sv
// Iterative execute-stage ALU: single-cycle logic/add/sub, serial SLL and shift-add MUL.
// Optional ITER_ALU_MULHI_EN turns op 111 into MULHI (high product half); otherwise op 111 is a NOP.
module iter_alu #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] srcA,
  input  logic [W-1:0] srcB,
  input  logic [D-1:0] dest,
  output logic         busy,
  output logic         done,
  output logic         write_en,
  output logic [D-1:0] waddr,
  output logic [W-1:0] data_in,
  output logic         ovf
);
  localparam int LW = $clog2(W);
  localparam int CW = LW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
`ifdef ITER_ALU_MULHI_EN
  localparam logic [2:0] OP_MHI = 3'b111;
`endif

  logic [1:0]     r_state;
  logic [2:0]     r_op;
  logic [D-1:0]   r_dest;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_sh;
  logic           r_sov;
  logic [2*W-1:0] r_prod;
  logic [2*W-1:0] r_mc;
  logic [CW-1:0]  r_cnt;
  logic           r_done;
  logic           r_we;
  logic [D-1:0]   r_waddr;
  logic [W-1:0]   r_data;
  logic           r_ovf;

  logic [LW-1:0]  w_n;
  logic [W:0]     w_sum;
  logic [2*W-1:0] w_pnx;
  logic [D-1:0]   w_dest;
  logic           w_multi;
  logic           w_fin;
  logic           w_wr;
  logic [W-1:0]   w_res;
  logic           w_ovf;

  assign w_n    = srcB[LW-1:0];
  assign w_sum  = {1'b0, srcA} + {1'b0, srcB};
  assign w_pnx  = r_prod + (r_b[0] ? r_mc : '0);
  assign w_dest = (r_state == S_IDLE) ? dest : r_dest;

  always_comb begin
    w_multi = 1'b0;
    case (op)
      OP_SLL:  w_multi = (w_n != '0);
      OP_MUL:  w_multi = 1'b1;
`ifdef ITER_ALU_MULHI_EN
      OP_MHI:  w_multi = 1'b1;
`endif
      default: w_multi = 1'b0;
    endcase
  end

  assign w_fin = (r_state == S_IDLE && start && !w_multi)
              || (r_state == S_RUN && r_cnt == CW'(1));

  // Finishing result: from live operands when leaving IDLE, from the iterators when leaving RUN.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_wr  = (w_dest != '0);
    if (r_state == S_IDLE) begin
      case (op)
        OP_ADD: {w_ovf, w_res} = w_sum;
        OP_SUB: begin
          w_res = srcA - srcB;
          w_ovf = (srcA < srcB);
        end
        OP_AND: w_res = srcA & srcB;
        OP_OR:  w_res = srcA | srcB;
        OP_XOR: w_res = srcA ^ srcB;
        OP_SLL: w_res = srcA;
        default: w_wr = 1'b0;
      endcase
    end else begin
      case (r_op)
        OP_SLL: begin
          w_res = {r_sh[W-2:0], 1'b0};
          w_ovf = r_sov | r_sh[W-1];
        end
`ifdef ITER_ALU_MULHI_EN
        OP_MHI: w_res = w_pnx[2*W-1:W];
`endif
        default: begin
          w_res = w_pnx[W-1:0];
          w_ovf = |w_pnx[2*W-1:W];
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= w_fin;
      r_we   <= w_fin & w_wr;
      if (w_fin) begin
        r_ovf <= w_ovf;
        if (w_wr) begin
          r_data  <= w_res;
          r_waddr <= w_dest;
        end
      end
      case (r_state)
        S_IDLE:  if (start) r_state <= w_multi ? S_RUN : S_DONE;
        S_RUN:   if (r_cnt == CW'(1)) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Iteration datapath; needs no reset since it is reloaded on every accept.
  always_ff @(posedge CLK) begin
    if (r_state == S_IDLE && start) begin
      r_op   <= op;
      r_dest <= dest;
      r_b    <= srcB;
      r_sh   <= srcA;
      r_sov  <= 1'b0;
      r_prod <= '0;
      r_mc   <= {{W{1'b0}}, srcA};
      r_cnt  <= (op == OP_SLL) ? CW'(w_n) : CW'(W);
    end else if (r_state == S_RUN) begin
      r_cnt  <= r_cnt - CW'(1);
      r_sh   <= r_sh << 1;
      r_sov  <= r_sov | r_sh[W-1];
      r_prod <= w_pnx;
      r_mc   <= r_mc << 1;
      r_b    <= r_b >> 1;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign write_en = r_we;
  assign waddr    = r_waddr;
  assign data_in  = r_data;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_iter_alu.sv
// Directed plus random checks of iter_alu against an arithmetic reference model.
// Honours ITER_ALU_MULHI_EN for the op 111 expectation.
module tb_iter_alu;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = $clog2(W);

  logic         CLK = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic [D-1:0] dest;
  logic         busy;
  logic         done;
  logic         write_en;
  logic [D-1:0] waddr;
  logic [W-1:0] data_in;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] m_data;
  logic [D-1:0] m_waddr;

  iter_alu #(.W(W), .D(D)) dut (
    .CLK(CLK), .reset(reset), .start(start), .op(op),
    .srcA(srcA), .srcB(srcB), .dest(dest),
    .busy(busy), .done(done), .write_en(write_en),
    .waddr(waddr), .data_in(data_in), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [D-1:0] d,
                        input bit poke);
    logic [2*W-1:0] p, s;
    logic [W-1:0]   er;
    logic           eo;
    logic           ew;
    int             lat, n, cyc;
    n  = int'(b[LW-1:0]);
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    s  = {{W{1'b0}}, a} << n;
    er = '0; eo = 1'b0; ew = 1'b1; lat = 0;
    case (o)
      3'd0: {eo, er} = {1'b0, a} + {1'b0, b};
      3'd1: begin er = a - b; eo = (a < b); end
      3'd2: er = a & b;
      3'd3: er = a | b;
      3'd4: er = a ^ b;
      3'd5: begin er = s[W-1:0]; eo = (s[2*W-1:W] != 0); lat = n; end
      3'd6: begin er = p[W-1:0]; eo = (p[2*W-1:W] != 0); lat = W; end
      default: begin
`ifdef ITER_ALU_MULHI_EN
        er = p[2*W-1:W]; lat = W;
`else
        ew = 1'b0;
`endif
      end
    endcase
    ew = ew && (d != 0);
    if (ew) begin
      m_data  = er;
      m_waddr = d;
    end
    op = o; srcA = a; srcB = b; dest = d; start = 1'b1;
    tick();
    start = 1'b0;
    srcA = W'($urandom); srcB = W'($urandom);
    dest = D'($urandom); op = 3'($urandom);
    cyc = 0;
    while (!done && cyc < W + 3) begin
      chk("busy_run", busy, 1);
      start = poke ? 1'($urandom) : 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("latency", cyc, lat);
    chk("busy_done", busy, 1);
    chk("write_en", write_en, ew);
    chk("waddr", waddr, m_waddr);
    chk("data_in", data_in, m_data);
    chk("ovf", ovf, eo);
    tick();
    chk("done_drop", done, 0);
    chk("busy_idle", busy, 0);
    chk("data_hold", data_in, m_data);
    chk("ovf_hold", ovf, eo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0;
    srcA = '0; srcB = '0; dest = '0;
    m_data = '0; m_waddr = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", write_en, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_data", data_in, 0);
    chk("rst_ovf", ovf, 0);

    run_op(3'd0, 8'hF0, 8'h20, 4'd3, 1'b0);
    run_op(3'd6, 8'd13, 8'd11, 4'd5, 1'b0);
    run_op(3'd6, 8'd20, 8'd20, 4'd7, 1'b1);
    run_op(3'd5, 8'b1000_0001, 8'd3, 4'd2, 1'b0);
    run_op(3'd5, 8'h5A, 8'd0, 4'd9, 1'b0);
    run_op(3'd5, 8'h01, 8'd7, 4'd4, 1'b1);
    run_op(3'd1, 8'd5, 8'd7, 4'd0, 1'b0);
    run_op(3'd2, 8'hCC, 8'hAA, 4'd1, 1'b0);
    run_op(3'd3, 8'hCC, 8'hAA, 4'd15, 1'b0);
    run_op(3'd4, 8'hCC, 8'hAA, 4'd6, 1'b0);

    // abort a MUL with reset while a stray start is presented mid-run
    op = 3'd6; srcA = 8'd9; srcB = 8'd9; dest = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_busy", busy, 1);
    tick();
    op = 3'd0; start = 1'b1;
    chk("abort_nodone1", done, 0);
    tick();
    start = 1'b0;
    chk("abort_nodone2", done, 0);
    tick();
    reset = 1'b1;
    chk("abort_nodone3", done, 0);
    tick();
    reset = 1'b0;
    m_data = '0; m_waddr = '0;
    chk("abort_busy0", busy, 0);
    chk("abort_done0", done, 0);
    chk("abort_we0", write_en, 0);
    chk("abort_data0", data_in, 0);
    chk("abort_waddr0", waddr, 0);
    chk("abort_ovf0", ovf, 0);
    run_op(3'd0, 8'd100, 8'd27, 4'd11, 1'b0);

    run_op(3'd7, 8'hFF, 8'hFF, 4'd12, 1'b0);

    for (int i = 0; i < 60; i++)
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
             D'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
